// File: rtl/e1000_intr_mod_if.sv
// Register-access bus for the interrupt moderation block.
// master drives write data and strobes; slave returns the ICR/IMS contents.
//   wdata      : write data shared by all write strobes
//   ims_wr     : set bits in the mask register
//   imc_wr     : clear bits in the mask register
//   ics_wr     : set bits in the cause register
//   icr_wr     : write-1-to-clear bits in the cause register
//   icr_rd     : cause register read strobe (clear-on-read)
//   icr_rdata  : current cause register value
//   ims_rdata  : current mask register value
interface e1000_intr_mod_if #(
  parameter int unsigned CAUSE_W = 32
) ();
  logic [CAUSE_W-1:0] wdata;
  logic               ims_wr;
  logic               imc_wr;
  logic               ics_wr;
  logic               icr_wr;
  logic               icr_rd;
  logic [CAUSE_W-1:0] icr_rdata;
  logic [CAUSE_W-1:0] ims_rdata;

  modport master (
    output wdata, ims_wr, imc_wr, ics_wr, icr_wr, icr_rd,
    input  icr_rdata, ims_rdata
  );

  modport slave (
    input  wdata, ims_wr, imc_wr, ics_wr, icr_wr, icr_rd,
    output icr_rdata, ims_rdata
  );
endinterface

// File: rtl/e1000_intr_mod.sv
// E1000-style interrupt cause/mask registers with per-channel interrupt
// moderation (packet delay timer plus absolute delay timer per channel).
//   aclk, aresetn : clock and asynchronous active-low reset
//   regs          : register bus (slave side), see e1000_intr_mod_if
//   cause_in      : immediate cause pulses, one bit per ICR bit
//   ch_event      : per-channel delayed event pulse
//   ch_ide        : per-channel delay enable, qualifies ch_event
//   ch_flush      : per-channel flush pulse, fires an armed channel now
//   ch_pdelay     : per-channel packet delay in ticks (0 = no delay)
//   ch_adelay     : per-channel absolute delay in ticks (0 = disabled)
//   irq           : registered level interrupt, |(ICR & IMS)
module e1000_intr_mod #(
  parameter int unsigned         NUM_CH   = 2,
  parameter int unsigned         CAUSE_W  = 32,
  parameter int unsigned         TIMER_W  = 16,
  parameter int unsigned         TICK_DIV = 128,
  parameter logic [NUM_CH*8-1:0] CH_CAUSE = {8'd7, 8'd0}
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  e1000_intr_mod_if.slave           regs,
  input  logic [CAUSE_W-1:0]        cause_in,
  input  logic [NUM_CH-1:0]         ch_event,
  input  logic [NUM_CH-1:0]         ch_ide,
  input  logic [NUM_CH-1:0]         ch_flush,
  input  logic [NUM_CH*TIMER_W-1:0] ch_pdelay,
  input  logic [NUM_CH*TIMER_W-1:0] ch_adelay,
  output logic                      irq
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_ARMED = 1'b1
  } ch_state_t;

  logic [PRE_W-1:0]   pre;
  logic               tick_c;
  logic [NUM_CH-1:0]  fire_c;
  logic [CAUSE_W-1:0] ch_set_c;
  logic [CAUSE_W-1:0] set_c;
  logic [CAUSE_W-1:0] clr_c;
  logic [CAUSE_W-1:0] icr;
  logic [CAUSE_W-1:0] ims;

  // Free-running delay-tick prescaler.
  assign tick_c = (pre == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pre <= '0;
    end else if (tick_c) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Per-channel moderation timers.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_t          state;
    logic [TIMER_W-1:0] pcnt;
    logic [TIMER_W-1:0] acnt;
    logic [TIMER_W-1:0] pdelay_c;
    logic [TIMER_W-1:0] adelay_c;
    logic               immediate_c;
    logic               expire_c;

    assign pdelay_c    = ch_pdelay[c*TIMER_W +: TIMER_W];
    assign adelay_c    = ch_adelay[c*TIMER_W +: TIMER_W];
    assign immediate_c = ch_event[c] && (!ch_ide[c] || (pdelay_c == '0));
    // A counter loaded with 0 never reaches the 1->0 transition, so it never fires.
    assign expire_c    = tick_c && ((pcnt == TIMER_W'(1)) || (acnt == TIMER_W'(1)));

    // An event always overrides a coincident flush or timer expiry.
    assign fire_c[c] = immediate_c ||
                       (!ch_event[c] && (state == CH_ARMED) && (ch_flush[c] || expire_c));

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        state <= CH_IDLE;
        pcnt  <= '0;
        acnt  <= '0;
      end else if (ch_event[c]) begin
        if (immediate_c) begin
          state <= CH_IDLE;
          pcnt  <= '0;
          acnt  <= '0;
        end else if (state == CH_IDLE) begin
          state <= CH_ARMED;
          pcnt  <= pdelay_c;
          acnt  <= adelay_c;
        end else begin
          pcnt <= pdelay_c;
          // Absolute timer keeps running through restarts; an expiry that
          // lands on an event cycle is held at 1 and fires on the next tick.
          if (tick_c && (acnt > TIMER_W'(1))) begin
            acnt <= acnt - TIMER_W'(1);
          end
        end
      end else if (state == CH_ARMED) begin
        if (fire_c[c]) begin
          state <= CH_IDLE;
          pcnt  <= '0;
          acnt  <= '0;
        end else if (tick_c) begin
          if (pcnt != '0) pcnt <= pcnt - TIMER_W'(1);
          if (acnt != '0) acnt <= acnt - TIMER_W'(1);
        end
      end
    end
  end

  // Map fired channels onto their ICR cause bits.
  always_comb begin
    ch_set_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (fire_c[c]) begin
        ch_set_c = ch_set_c | (CAUSE_W'(1) << CH_CAUSE[c*8 +: 8]);
      end
    end
  end

  assign set_c = cause_in | ch_set_c | (regs.ics_wr ? regs.wdata : '0);
  assign clr_c = (regs.icr_wr ? regs.wdata : '0) | {CAUSE_W{regs.icr_rd}};

  // Cause/mask registers and registered interrupt level; set beats clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      icr <= '0;
      ims <= '0;
      irq <= 1'b0;
    end else begin
      icr <= (icr & ~clr_c) | set_c;
      ims <= (ims | (regs.ims_wr ? regs.wdata : '0)) & ~(regs.imc_wr ? regs.wdata : '0);
      irq <= |(icr & ims);
    end
  end

  assign regs.icr_rdata = icr;
  assign regs.ims_rdata = ims;

endmodule

// File: tb/tb_e1000_intr_mod.sv
// Directed bench for e1000_intr_mod (TICK_DIV=4, NUM_CH=2, causes {7,0}).
// Stimulus pushes time-stamped expectations; a negedge monitor checks them.
module tb_e1000_intr_mod;

  localparam int K_ICR = 0;
  localparam int K_IMS = 1;
  localparam int K_IRQ = 2;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        aclk;
  logic        aresetn;
  logic [31:0] cause_in;
  logic [1:0]  ch_event;
  logic [1:0]  ch_ide;
  logic [1:0]  ch_flush;
  logic [31:0] ch_pdelay;
  logic [31:0] ch_adelay;
  logic        irq;

  int unsigned cycle = 0;
  int          vectors = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  e1000_intr_mod_if #(.CAUSE_W(32)) regs ();

  e1000_intr_mod #(
    .NUM_CH  (2),
    .CAUSE_W (32),
    .TIMER_W (16),
    .TICK_DIV(4),
    .CH_CAUSE({8'd7, 8'd0})
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .regs     (regs.slave),
    .cause_in (cause_in),
    .ch_event (ch_event),
    .ch_ide   (ch_ide),
    .ch_flush (ch_flush),
    .ch_pdelay(ch_pdelay),
    .ch_adelay(ch_adelay),
    .irq      (irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cycle <= cycle + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge aclk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cycle) begin
        logic [31:0] act;
        case (exp_q[i].kind)
          K_ICR:   act = regs.icr_rdata;
          K_IMS:   act = regs.ims_rdata;
          default: act = {31'b0, irq};
        endcase
        vectors++;
        if (act !== exp_q[i].val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got 0x%08h, want 0x%08h",
                   exp_q[i].name, cycle, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic chk(input int unsigned dc, input int kind, input logic [31:0] v,
                     input string nm);
    exp_t e;
    e.cyc  = cycle + dc;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    regs.wdata  = '0;
    regs.ims_wr = 1'b0;
    regs.imc_wr = 1'b0;
    regs.ics_wr = 1'b0;
    regs.icr_wr = 1'b0;
    regs.icr_rd = 1'b0;
    cause_in    = '0;
    ch_event    = '0;
    ch_flush    = '0;
  endtask

  // Clear all causes and masks, then let irq settle.
  task automatic cleanup();
    regs.wdata  = 32'hFFFF_FFFF;
    regs.imc_wr = 1'b1;
    regs.icr_rd = 1'b1;
    step(1);
    idle_inputs();
    step(2);
  endtask

  initial begin
    aresetn   = 1'b0;
    idle_inputs();
    ch_ide    = '0;
    ch_pdelay = '0;
    ch_adelay = '0;
    step(3);
    aresetn = 1'b1;
    chk(1, K_ICR, 32'h0, "reset_icr");
    chk(1, K_IMS, 32'h0, "reset_ims");
    chk(1, K_IRQ, 32'h0, "reset_irq");
    step(2);

    // Immediate cause with mask, then clear-on-read.
    regs.ims_wr = 1'b1; regs.wdata = 32'h1; cause_in = 32'h1;
    chk(1, K_ICR, 32'h1, "imm_icr_set");
    chk(1, K_IMS, 32'h1, "imm_ims_set");
    chk(1, K_IRQ, 32'h0, "imm_irq_lat0");
    chk(2, K_IRQ, 32'h1, "imm_irq_lat1");
    step(1); idle_inputs();
    step(4);
    regs.icr_rd = 1'b1;
    chk(1, K_ICR, 32'h0, "rd_icr_clr");
    chk(1, K_IRQ, 32'h1, "rd_irq_hold");
    chk(2, K_IRQ, 32'h0, "rd_irq_drop");
    step(1); idle_inputs();
    step(3);
    cleanup();

    // Software cause set and write-1-to-clear.
    regs.ics_wr = 1'b1; regs.wdata = 32'h30;
    chk(1, K_ICR, 32'h30, "ics_set");
    step(1); idle_inputs();
    regs.icr_wr = 1'b1; regs.wdata = 32'h10;
    chk(1, K_ICR, 32'h20, "icr_w1c");
    step(1); idle_inputs();
    step(1);
    cleanup();

    // Set beats clear on ICR; clear beats set on IMS.
    cause_in = 32'h4; regs.icr_wr = 1'b1; regs.wdata = 32'h4;
    chk(1, K_ICR, 32'h4, "icr_set_wins");
    step(1); idle_inputs();
    regs.ims_wr = 1'b1; regs.imc_wr = 1'b1; regs.wdata = 32'h4;
    chk(1, K_IMS, 32'h0, "ims_imc_wins");
    step(1); idle_inputs();
    regs.ims_wr = 1'b1; regs.wdata = 32'h4;
    chk(1, K_IMS, 32'h4, "ims_set");
    chk(1, K_IRQ, 32'h0, "masked_irq_low");
    chk(2, K_IRQ, 32'h1, "unmasked_irq");
    step(1); idle_inputs();
    step(2);
    cleanup();
    vectors++;
    if (regs.icr_rdata !== 32'h0 || regs.ims_rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL cleanup_quiet: icr=0x%08h ims=0x%08h irq=%b",
               regs.icr_rdata, regs.ims_rdata, irq);
    end

    // Immediate channel fires: ch0 via ide=0, ch1 via pdelay=0.
    ch_ide = 2'b10; ch_pdelay = {16'd0, 16'd4}; ch_event = 2'b11;
    chk(1, K_ICR, 32'h81, "ch_immediate");
    step(1); idle_inputs();
    step(1);
    cleanup();

    // Packet delay of 4 ticks; a live pdelay change must not affect it.
    ch_ide = 2'b01; ch_pdelay = {16'd0, 16'd4}; ch_adelay = '0; ch_event = 2'b01;
    chk(13, K_ICR, 32'h0, "pdly_not_early");
    chk(17, K_ICR, 32'h1, "pdly_fired");
    step(1); idle_inputs();
    ch_pdelay = {16'd0, 16'd1};
    step(17);
    ch_pdelay = {16'd0, 16'd4};
    cleanup();

    // Events every 3 ticks keep pcnt alive; absolute delay of 10 ticks fires.
    ch_adelay = {16'd0, 16'd10};
    for (int k = 0; k < 4; k++) begin
      ch_event = 2'b01;
      if (k == 0) begin
        chk(37, K_ICR, 32'h0, "adly_not_early");
        chk(41, K_ICR, 32'h1, "adly_fired");
      end
      step(1); idle_inputs();
      step(11);
    end
    ch_adelay = '0;
    cleanup();

    // Flush of an armed ch1, then a second flush on the idle channel.
    ch_ide = 2'b10; ch_pdelay = {16'd8, 16'd4}; ch_event = 2'b10;
    regs.ims_wr = 1'b1; regs.wdata = 32'h80;
    chk(3, K_ICR, 32'h0, "flush_armed_quiet");
    step(1); idle_inputs();
    step(2);
    ch_flush = 2'b10;
    chk(1, K_ICR, 32'h80, "flush_fire");
    chk(2, K_IRQ, 32'h1, "flush_irq");
    step(1); idle_inputs();
    vectors++;
    if (regs.icr_rdata[7] !== 1'b1) begin
      errors++;
      $display("FAIL flush_fire_direct: icr=0x%08h", regs.icr_rdata);
    end
    step(1);
    regs.icr_wr = 1'b1; regs.wdata = 32'h80;
    chk(1, K_ICR, 32'h0, "flush_clr");
    chk(2, K_IRQ, 32'h0, "flush_irq_drop");
    step(1); idle_inputs();
    step(1);
    ch_flush = 2'b10;
    chk(1, K_ICR, 32'h0, "flush_idle_noop");
    chk(38, K_ICR, 32'h0, "flush_no_late_fire");
    step(1); idle_inputs();
    vectors++;
    if (regs.icr_rdata !== 32'h0) begin
      errors++;
      $display("FAIL flush_idle_direct: icr=0x%08h", regs.icr_rdata);
    end
    step(40);
    cleanup();
    vectors++;
    if (regs.icr_rdata !== 32'h0 || regs.ims_rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL flush_cleanup_quiet: icr=0x%08h ims=0x%08h irq=%b",
               regs.icr_rdata, regs.ims_rdata, irq);
    end

    // Reset while ch0 is armed discards the pending fire.
    ch_ide = 2'b01; ch_pdelay = {16'd0, 16'd4}; ch_event = 2'b01;
    regs.ims_wr = 1'b1; regs.wdata = 32'h1;
    step(1); idle_inputs();
    step(2);
    aresetn = 1'b0;
    step(1);
    aresetn = 1'b1;
    chk(1, K_ICR, 32'h0, "rst_icr");
    chk(1, K_IMS, 32'h0, "rst_ims");
    chk(1, K_IRQ, 32'h0, "rst_irq");
    step(1);
    regs.ims_wr = 1'b1; regs.wdata = 32'h1;
    chk(1, K_IMS, 32'h1, "rst_ims_reenable");
    chk(84, K_ICR, 32'h0, "rst_no_fire");
    chk(84, K_IRQ, 32'h0, "rst_irq_quiet");
    step(1); idle_inputs();
    step(90);
    cleanup();
    vectors++;
    if (regs.icr_rdata !== 32'h0 || regs.ims_rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL final_quiet: icr=0x%08h ims=0x%08h irq=%b",
               regs.icr_rdata, regs.ims_rdata, irq);
    end

    // Drain any outstanding expectations within a bounded window.
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) step(1);
    while (exp_q.size() > 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: never checked, due cycle %0d, now %0d",
               exp_q[0].name, exp_q[0].cyc, cycle);
      void'(exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/e1000_intr_mod.md
E1000_INTR_MOD -- requirements
Module: e1000_intr_mod

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of delayed-interrupt channels (TX, RX, further queues).
REQ-002 SHALL have parameter CAUSE_W, default 32, width of the ICR/IMS cause vectors.
REQ-003 SHALL have parameter TIMER_W, default 16, width of each delay value and counter.
REQ-004 SHALL have parameter TICK_DIV, default 128, aclk cycles per delay tick (1.024 us at 125 MHz).
REQ-005 SHALL have parameter CH_CAUSE, default {8'd7,8'd0}, packed NUM_CH x 8-bit ICR bit index per channel; channel 0 is the LSB field.
REQ-006 aclk  input  1  sole clock; all logic on rising edge.
REQ-007 aresetn  input  1  asynchronous, active-low reset.
REQ-008 wdata  input  CAUSE_W  register write data for all write strobes.
REQ-009 ims_wr, imc_wr, ics_wr, icr_wr  input  1 each  single-cycle write strobes (mask set, mask clear, cause set, write-1-to-clear).
REQ-010 icr_rd  input  1  ICR read strobe; clear-on-read.
REQ-011 icr_rdata, ims_rdata  output  CAUSE_W each  current ICR and IMS values, direct from registers.
REQ-012 cause_in  input  CAUSE_W  immediate event pulses, one bit per cause.
REQ-013 ch_event, ch_ide, ch_flush  input  NUM_CH each  per-channel delayed event pulse, delay-enable qualifier, flush pulse.
REQ-014 ch_pdelay, ch_adelay  input  NUM_CH*TIMER_W each  packet (TIDV-style) and absolute (TADV-style) delays in ticks; 0 disables that delay.
REQ-015 irq  output  1  active-high level interrupt request.

Function
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 free-running from reset; tick is high one cycle when count = TICK_DIV-1.
REQ-017 Each channel SHALL have states IDLE and ARMED, a packet counter pcnt and an absolute counter acnt.
REQ-018 ch_event with ch_ide=0 or pdelay=0: channel SHALL fire immediately and go IDLE, discarding any pending delay.
REQ-019 ch_event with ch_ide=1, pdelay!=0, state IDLE: pcnt<=pdelay, acnt<=adelay, state->ARMED.
REQ-020 ch_event with ch_ide=1, pdelay!=0, state ARMED: pcnt<=pdelay (restart), acnt unchanged.
REQ-021 In ARMED on tick: pcnt and acnt (if nonzero) SHALL decrement; fire when either transitions 1->0; state->IDLE.
REQ-022 acnt loaded with 0 SHALL never cause a fire.
REQ-023 ch_flush in ARMED: fire, state->IDLE; in IDLE: no effect.
REQ-024 Event and tick-expiry in the same cycle: event rule (REQ-018..020) SHALL take priority.
REQ-025 Fire SHALL set ICR bit CH_CAUSE[ch] at the next aclk edge (1-cycle latency from fire condition).
REQ-026 ICR next = (ICR & ~clr) | set; set = cause_in | fired channel bits | (ics_wr ? wdata : 0); clr = (icr_wr ? wdata : 0) | (icr_rd ? all ones : 0); set SHALL win over clear on the same bit in the same cycle.
REQ-027 IMS next = (IMS | (ims_wr?wdata:0)) & ~(imc_wr?wdata:0); imc wins over ims on the same bit.
REQ-028 irq SHALL be registered: irq <= |(ICR & IMS); asserts 1 cycle after the ICR/IMS update enabling it.
REQ-029 Changes to ch_pdelay/ch_adelay while ARMED SHALL take effect only on the next load.
REQ-030 Counters SHALL not wrap below 0.

Reset
REQ-031 On aresetn low, asynchronously: ICR=0, IMS=0, irq=0, prescaler=0, all channels IDLE, pcnt=acnt=0.
REQ-032 Reset mid-delay SHALL discard pending fires; no irq after release until a new cause.

Verification (TICK_DIV=4, NUM_CH=2, CH_CAUSE={7,0})
REQ-033 ims_wr wdata=0x1, cause_in=0x1 at cycle T -> ICR=0x1 at T+1, irq=1 at T+2; icr_rd at T+5 -> ICR=0 at T+6, irq=0 at T+7.
REQ-034 ch0 ide=1 pdelay=4 adelay=0 single ch_event -> ICR[0] sets after 4 ticks (13..16 cycles), not earlier.
REQ-035 ch0 pdelay=4 adelay=10, ch_event every 3 ticks -> pcnt never expires; ICR[0] sets after 10 ticks from first event via absolute timer.
REQ-036 ch1 armed (pdelay=8), ch_flush[1] -> ICR[7] set next cycle, channel IDLE; second flush -> no change.
REQ-037 cause_in bit 2 and icr_wr wdata=0x4 same cycle -> ICR[2]=1; ims_wr and imc_wr wdata=0x4 same cycle -> IMS[2]=0.
REQ-038 aresetn low for 1 cycle while ch0 ARMED (pdelay=4) -> no ICR bit after release over 20 ticks; irq stays 0.
